dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares one synchronous data-memory port between the two processing elements (PE1, PE2).
//   Sits between the PE load/store stages (driven by MemWrite1/2, ResultSrc1/2 decode) and the
//   single-port data memory. Round-robin arbitration, one access per cycle, stalls the losing PE,
//   routes read data back to the requester one cycle later, counts contention cycles.
// PARAMETERS
//   ADDR_W  32  address width
//   DATA_W  32  data width
//   CNT_W   16  width of saturating conflict counter
// PORTS
//   clk           in   1       single clock, rising edge
//   rst           in   1       synchronous, active-high reset
//   req1/req2     in   1       PE access request (load or store)
//   we1/we2       in   1       1 = store, 0 = load
//   addr1/addr2   in   ADDR_W  byte address
//   wdata1/wdata2 in   DATA_W  store data
//   stall1/stall2 out  1       request present but not granted this cycle
//   rvalid1/2     out  1       load data valid for that PE this cycle
//   rdata1/rdata2 out  DATA_W  load data (0 when rvalid low)
//   mem_en        out  1       memory access this cycle
//   mem_we        out  1       memory write enable
//   mem_addr      out  ADDR_W  memory address
//   mem_wdata     out  DATA_W  memory write data
//   mem_rdata     in   DATA_W  memory read data, valid cycle after a read access
//   conflict_cnt  out  CNT_W   cycles in which req1 & req2 both high (saturating)
// BEHAVIOUR
// - Reset (rst=1 at posedge): rr_ptr=PE1, rd_pend=0, rvalid1/2=0, conflict_cnt=0. rst dominates all.
// - Grant (combinational): only one req -> that PE; both -> PE selected by rr_ptr; none -> no grant.
// - stallN = reqN & ~gntN (combinational, same cycle). Stalled PE holds req/we/addr/wdata stable;
//   the arbiter latches no request fields.
// - Memory drive (combinational): mem_en=1, mem_we/addr/wdata from granted PE; no grant -> mem_en=0,
//   mem_we=0, mem_addr=0, mem_wdata=0.
// - rr_ptr: on any grant, rr_ptr <= the non-granted PE; unchanged on idle cycles.
//   Continuous contention therefore alternates PE1, PE2, PE1, ... (no starvation, max wait 1 cycle).
// - Read tracking: on a granted load, rd_pend <= {1, id}; otherwise rd_pend.valid <= 0.
//   rvalidN = rd_pend.valid & (rd_pend.id==N) (registered); rdataN = rvalidN ? mem_rdata : 0.
//   Load latency: grant in cycle T -> rvalid/rdata in cycle T+1. Back-to-back loads pipeline fully.
// - Stores: single cycle, no response pulse; a store granted in T is visible to a load granted in T+1.
// - Same-cycle store/load to same address: grant order defines order; loser sees post-store data.
// - conflict_cnt: +1 every cycle req1&req2; holds at 2^CNT_W-1 (no wrap).
// - Reset mid-operation: pending load discarded; no rvalid in the cycle after reset.
// TESTING
//   T1 reset; req1 load 0x10 (mem[0x10]=0x1234) -> cyc0 mem_en=1, addr 0x10, stall1=0;
//      cyc1 rvalid1=1, rdata1=0x1234, rvalid2=0.
//   T2 reset; req1,req2 loads held 4 cycles -> grants PE1,PE2,PE1,PE2; stall2,stall1 alternate;
//      conflict_cnt=4.
//   T3 rr_ptr=PE1; PE1 store 0x20=0xDEAD, PE2 load 0x20 same cycle -> cyc0 store, stall2=1;
//      cyc1 PE2 load granted; cyc2 rvalid2=1, rdata2=0xDEAD.
//   T4 CNT_W=4; 20 consecutive contention cycles -> conflict_cnt=15, stays 15.
//   T5 PE2 load granted cyc0; rst=1 in cyc0 -> cyc1 rvalid2=0, rr_ptr=PE1, conflict_cnt=0.
//   T6 no requests 3 cycles after PE1 grant -> mem_en=0, stalls 0, next single req2 granted
//      immediately; following contention cycle grants PE1.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of PE-side and memory-side signals shared between the two PEs, the arbiter and the
// single-port data memory. The slave modport is the arbiter's view, the master modport is the
// view of whatever drives the PEs and models the memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              req1,    req2;
  logic              we1,     we2;
  logic [ADDR_W-1:0] addr1,   addr2;
  logic [DATA_W-1:0] wdata1,  wdata2;
  logic              stall1,  stall2;
  logic              rvalid1, rvalid2;
  logic [DATA_W-1:0] rdata1,  rdata2;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  conflict_cnt;

  modport slave (
    input  req1, req2, we1, we2, addr1, addr2, wdata1, wdata2, mem_rdata,
    output stall1, stall2, rvalid1, rvalid2, rdata1, rdata2,
           mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt
  );

  modport master (
    output req1, req2, we1, we2, addr1, addr2, wdata1, wdata2, mem_rdata,
    input  stall1, stall2, rvalid1, rvalid2, rdata1, rdata2,
           mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous data-memory port between PE1 and PE2.
// One access per cycle; the losing PE is stalled and must hold its request fields.
// Load data returns to the requester one cycle after its grant.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            rst,
  dmem_arbiter_if.slave  bus
);

  // rr_ptr: 0 = PE1 wins next contention, 1 = PE2 wins next contention
  logic             rr_ptr_q,  rr_ptr_d;
  logic             rd_vld_q,  rd_vld_d;
  logic             rd_id_q,   rd_id_d;   // 0 = PE1, 1 = PE2
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             gnt1, gnt2;
  logic             both_req;

  // Grant decision, memory drive and stall generation
  always_comb begin
    both_req      = bus.req1 & bus.req2;
    gnt1          = bus.req1 & (~bus.req2 | ~rr_ptr_q);
    gnt2          = bus.req2 & (~bus.req1 |  rr_ptr_q);
    bus.stall1    = bus.req1 & ~gnt1;
    bus.stall2    = bus.req2 & ~gnt2;
    bus.mem_en    = gnt1 | gnt2;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt1) begin
      bus.mem_we    = bus.we1;
      bus.mem_addr  = bus.addr1;
      bus.mem_wdata = bus.wdata1;
    end else if (gnt2) begin
      bus.mem_we    = bus.we2;
      bus.mem_addr  = bus.addr2;
      bus.mem_wdata = bus.wdata2;
    end
  end

  // Next-state: pointer flips to the non-granted PE, load tracking, saturating contention count
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt1)      rr_ptr_d = 1'b1;
    else if (gnt2) rr_ptr_d = 1'b0;
    rd_vld_d = (gnt1 & ~bus.we1) | (gnt2 & ~bus.we2);
    rd_id_d  = gnt2;
    cnt_d    = cnt_q;
    if (both_req && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // State registers; reset discards any pending load
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_id_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rd_vld_q <= rd_vld_d;
      rd_id_q  <= rd_id_d;
      cnt_q    <= cnt_d;
    end
  end

  // Route returning read data to the PE that issued the load; zero otherwise
  always_comb begin
    bus.rvalid1      = rd_vld_q & ~rd_id_q;
    bus.rvalid2      = rd_vld_q &  rd_id_q;
    bus.rdata1       = bus.rvalid1 ? bus.mem_rdata : '0;
    bus.rdata2       = bus.rvalid2 ? bus.mem_rdata : '0;
    bus.conflict_cnt = cnt_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous memory model behind the shared port.
// The conflict counter is built narrow so saturation is reached quickly.
module tb_dmem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: write on store grant, read data registered one cycle after a load grant
  logic [DATA_W-1:0] mem [0:255];
  logic [DATA_W-1:0] mem_rdata_q;
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) mem_rdata_q <= mem[bus.mem_addr[7:0]];
  end
  assign bus.mem_rdata = mem_rdata_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic r2, input logic w2, input logic [31:0] a2, input logic [31:0] d2);
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    bus.req2 = r2; bus.we2 = w2; bus.addr2 = a2; bus.wdata2 = d2;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check("rst_rvalid1", {31'b0, bus.rvalid1}, 32'd0);
    check("rst_rvalid2", {31'b0, bus.rvalid2}, 32'd0);
    check("rst_cnt", {28'b0, bus.conflict_cnt}, 32'd0);
    check("rst_mem_en", {31'b0, bus.mem_en}, 32'd0);

    // preload through the arbiter: PE1 stores 0x10, PE2 stores 0x14
    drive(1'b1, 1'b1, 32'h10, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0);
    check("pre_mem_we", {31'b0, bus.mem_we}, 32'd1);
    check("pre_mem_wdata", bus.mem_wdata, 32'h1234);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h14, 32'h5678);
    tick();
    check("pre_store_no_rvalid", {31'b0, bus.rvalid2}, 32'd0);

    // T1: single load from PE1
    do_reset();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t1_mem_en", {31'b0, bus.mem_en}, 32'd1);
    check("t1_mem_addr", bus.mem_addr, 32'h10);
    check("t1_mem_we", {31'b0, bus.mem_we}, 32'd0);
    check("t1_stall1", {31'b0, bus.stall1}, 32'd0);
    tick();
    idle();
    check("t1_rvalid1", {31'b0, bus.rvalid1}, 32'd1);
    check("t1_rdata1", bus.rdata1, 32'h1234);
    check("t1_rvalid2", {31'b0, bus.rvalid2}, 32'd0);
    check("t1_rdata2", bus.rdata2, 32'h0);

    // T2: continuous contention alternates PE1, PE2, PE1, PE2
    do_reset();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
    for (int i = 0; i < 4; i++) begin
      logic p1;
      p1 = (i % 2 == 0);
      check($sformatf("t2_stall1_%0d", i), {31'b0, bus.stall1}, {31'b0, !p1});
      check($sformatf("t2_stall2_%0d", i), {31'b0, bus.stall2}, {31'b0, p1});
      check($sformatf("t2_addr_%0d", i), bus.mem_addr, p1 ? 32'h10 : 32'h14);
      tick();
      check($sformatf("t2_rvalid1_%0d", i), {31'b0, bus.rvalid1}, {31'b0, p1});
      check($sformatf("t2_rdata_%0d", i), p1 ? bus.rdata1 : bus.rdata2, p1 ? 32'h1234 : 32'h5678);
    end
    idle();
    check("t2_cnt", {28'b0, bus.conflict_cnt}, 32'd4);

    // T3: same-cycle store (PE1) and load (PE2) to one address
    do_reset();
    drive(1'b1, 1'b1, 32'h20, 32'hDEAD, 1'b1, 1'b0, 32'h20, 32'h0);
    check("t3_mem_we", {31'b0, bus.mem_we}, 32'd1);
    check("t3_stall2", {31'b0, bus.stall2}, 32'd1);
    check("t3_stall1", {31'b0, bus.stall1}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    check("t3_c1_rvalid1", {31'b0, bus.rvalid1}, 32'd0);
    check("t3_c1_stall2", {31'b0, bus.stall2}, 32'd0);
    check("t3_c1_mem_addr", bus.mem_addr, 32'h20);
    tick();
    idle();
    check("t3_rvalid2", {31'b0, bus.rvalid2}, 32'd1);
    check("t3_rdata2", bus.rdata2, 32'hDEAD);

    // T4: saturation of the 4-bit contention counter
    do_reset();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) check("t4_cnt14", {28'b0, bus.conflict_cnt}, 32'd14);
      if (i == 15) check("t4_cnt15", {28'b0, bus.conflict_cnt}, 32'd15);
      if (i == 20) check("t4_cnt20", {28'b0, bus.conflict_cnt}, 32'd15);
    end
    idle();

    // T5: reset in the cycle of a PE2 load grant
    do_reset();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check("t5_rvalid2", {31'b0, bus.rvalid2}, 32'd0);
    check("t5_cnt", {28'b0, bus.conflict_cnt}, 32'd0);
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
    check("t5_rr_stall2", {31'b0, bus.stall2}, 32'd1);
    // reset during a PE1 grant must still leave the pointer at PE1
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
    check("t5_rvalid1", {31'b0, bus.rvalid1}, 32'd0);
    check("t5b_rr_stall2", {31'b0, bus.stall2}, 32'd1);
    check("t5b_rr_stall1", {31'b0, bus.stall1}, 32'd0);
    tick();
    idle();

    // T6: idle cycles after a PE1 grant, then single PE2, then contention
    do_reset();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    idle();
    check("t6_rvalid1", {31'b0, bus.rvalid1}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t6_mem_en_%0d", i), {31'b0, bus.mem_en}, 32'd0);
      check($sformatf("t6_stalls_%0d", i), {30'b0, bus.stall1, bus.stall2}, 32'd0);
      check($sformatf("t6_addr_%0d", i), bus.mem_addr, 32'h0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
    check("t6_single2_stall", {31'b0, bus.stall2}, 32'd0);
    check("t6_single2_addr", bus.mem_addr, 32'h14);
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
    check("t6_rvalid2", {31'b0, bus.rvalid2}, 32'd1);
    check("t6_rdata2", bus.rdata2, 32'h5678);
    check("t6_cont_stall1", {31'b0, bus.stall1}, 32'd0);
    check("t6_cont_stall2", {31'b0, bus.stall2}, 32'd1);
    check("t6_cont_addr", bus.mem_addr, 32'h10);
    tick();
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
